// File: rtl/set_scan_ctrl_if.sv
// Set-side interface of set_scan_ctrl: job request (en/central/radius/mode) and result
// (busy/valid/candidate). The master drives the request; the slave is the controller.
interface set_scan_ctrl_if;
   logic        en;
   logic [23:0] central;
   logic [11:0] radius;
   logic [1:0]  mode;
   logic        busy;
   logic        valid;
   logic [7:0]  candidate;

   modport master (
      output en, central, radius, mode,
      input  busy, valid, candidate
   );

   modport slave (
      input  en, central, radius, mode,
      output busy, valid, candidate
   );
endinterface

// File: rtl/set_scan_ctrl.sv
// Scans the 8x8 grid through one shared circle-membership cell and counts points matching
// the latched mode. Define SET_CTRL_MODE3_EN to build circle C and the exactly-two-of-three mode.
module set_scan_ctrl (
   input  logic           clk,
   input  logic           rst_n,
   set_scan_ctrl_if.slave set_if,
   output logic [5:0]     cell_now,
   output logic [3:0]     cell_cx,
   output logic [3:0]     cell_cy,
   output logic [3:0]     cell_r,
   input  logic           cell_in
);

   typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] cen_ab_q, cen_ab_d;
   logic [7:0]  rad_ab_q, rad_ab_d;
   logic [1:0]  mode_q, mode_d;
   logic [5:0]  idx_q, idx_d;
   logic [1:0]  sel_q, sel_d;
   logic        hit_a_q, hit_a_d;
   logic        hit_b_q, hit_b_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [7:0]  cand_q, cand_d;
   logic [1:0]  last_sel;
   logic        point_hit;

`ifdef SET_CTRL_MODE3_EN
   logic [7:0]  cen_c_q, cen_c_d;
   logic [3:0]  rad_c_q, rad_c_d;
`else
   logic        unused_c;
   assign unused_c = ^{set_if.central[7:0], set_if.radius[3:0]};
`endif

   // Index of the last circle evaluated for each point, from the latched mode.
   always_comb begin
      last_sel = 2'd0;
      case (mode_q)
         2'd1, 2'd2: last_sel = 2'd1;
`ifdef SET_CTRL_MODE3_EN
         2'd3:       last_sel = 2'd2;
`endif
         default:    last_sel = 2'd0;
      endcase
   end

   // Predicate on the last circle cycle: registered earlier hits plus the live cell result.
   always_comb begin
      point_hit = cell_in;
      case (mode_q)
         2'd1:    point_hit = hit_a_q & cell_in;
         2'd2:    point_hit = hit_a_q ^ cell_in;
`ifdef SET_CTRL_MODE3_EN
         2'd3:    point_hit = (({1'b0, hit_a_q} + {1'b0, hit_b_q} + {1'b0, cell_in}) == 2'd2);
`endif
         default: point_hit = cell_in;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cen_ab_d = cen_ab_q;
      rad_ab_d = rad_ab_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      sel_d    = sel_q;
      hit_a_d  = hit_a_q;
      hit_b_d  = hit_b_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
`ifdef SET_CTRL_MODE3_EN
      cen_c_d  = cen_c_q;
      rad_c_d  = rad_c_q;
`endif
      case (state_q)
         StIdle: begin
            if (set_if.en) begin
               cen_ab_d = set_if.central[23:8];
               rad_ab_d = set_if.radius[11:4];
`ifdef SET_CTRL_MODE3_EN
               cen_c_d  = set_if.central[7:0];
               rad_c_d  = set_if.radius[3:0];
`endif
               mode_d   = set_if.mode;
               idx_d    = 6'd0;
               sel_d    = 2'd0;
               hit_a_d  = 1'b0;
               hit_b_d  = 1'b0;
               cnt_d    = 7'd0;
               state_d  = StEval;
            end
         end
         StEval: begin
            if (sel_q == 2'd0) hit_a_d = cell_in;
            if (sel_q == 2'd1) hit_b_d = cell_in;
            if (sel_q == last_sel) begin
               if (point_hit) cnt_d = cnt_q + 7'd1;
               sel_d = 2'd0;
               if (idx_q == 6'd63) begin
                  cand_d  = {1'b0, cnt_d};
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end else begin
               sel_d = sel_q + 2'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cen_ab_q <= '0;
         rad_ab_q <= '0;
         mode_q   <= '0;
         idx_q    <= '0;
         sel_q    <= '0;
         hit_a_q  <= 1'b0;
         hit_b_q  <= 1'b0;
         cnt_q    <= '0;
         cand_q   <= '0;
`ifdef SET_CTRL_MODE3_EN
         cen_c_q  <= '0;
         rad_c_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cen_ab_q <= cen_ab_d;
         rad_ab_q <= rad_ab_d;
         mode_q   <= mode_d;
         idx_q    <= idx_d;
         sel_q    <= sel_d;
         hit_a_q  <= hit_a_d;
         hit_b_q  <= hit_b_d;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
`ifdef SET_CTRL_MODE3_EN
         cen_c_q  <= cen_c_d;
         rad_c_q  <= rad_c_d;
`endif
      end
   end

   // Cell drive comes only from registers and is parked at zero outside EVAL.
   always_comb begin
      cell_now = 6'd0;
      cell_cx  = 4'd0;
      cell_cy  = 4'd0;
      cell_r   = 4'd0;
      if (state_q == StEval) begin
         cell_now = idx_q;
         case (sel_q)
            2'd0: begin
               cell_cx = cen_ab_q[15:12];
               cell_cy = cen_ab_q[11:8];
               cell_r  = rad_ab_q[7:4];
            end
            2'd1: begin
               cell_cx = cen_ab_q[7:4];
               cell_cy = cen_ab_q[3:0];
               cell_r  = rad_ab_q[3:0];
            end
`ifdef SET_CTRL_MODE3_EN
            2'd2: begin
               cell_cx = cen_c_q[7:4];
               cell_cy = cen_c_q[3:0];
               cell_r  = rad_c_q;
            end
`endif
            default: begin
               cell_cx = 4'd0;
               cell_cy = 4'd0;
               cell_r  = 4'd0;
            end
         endcase
      end
   end

   assign set_if.busy      = (state_q != StIdle);
   assign set_if.valid     = (state_q == StDone);
   assign set_if.candidate = cand_q;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Bench for set_scan_ctrl: behavioural membership cell, grid-walk count model and a
// scoreboard checking candidate value and valid timing for every job.
module tb_set_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] cell_now;
   logic [3:0] cell_cx, cell_cy, cell_r;
   logic       cell_in;

   set_scan_ctrl_if sif();

   set_scan_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_if   (sif),
      .cell_now (cell_now),
      .cell_cx  (cell_cx),
      .cell_cy  (cell_cy),
      .cell_r   (cell_r),
      .cell_in  (cell_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   int exp_cnt_q[$];
   int exp_cyc_q[$];
   int sb_cnt, sb_cyc;

   function automatic bit in_circ(int x, int y, int cx, int cy, int r);
      return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
   endfunction

   always_comb cell_in = in_circ(int'(cell_now[2:0]) + 1, int'(cell_now[5:3]) + 1,
                                 int'(cell_cx), int'(cell_cy), int'(cell_r));

   function automatic int k_of(logic [1:0] md);
      if (md == 2'd0) return 1;
      if (md != 2'd3) return 2;
`ifdef SET_CTRL_MODE3_EN
      return 3;
`else
      return 1;
`endif
   endfunction

   function automatic int model_count(logic [23:0] c, logic [11:0] r, logic [1:0] md);
      int n = 0;
      bit a, b, cc, p;
      for (int y = 1; y <= 8; y++) begin
         for (int x = 1; x <= 8; x++) begin
            a  = in_circ(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
            b  = in_circ(x, y, int'(c[15:12]), int'(c[11:8]), int'(r[7:4]));
            cc = in_circ(x, y, int'(c[7:4]), int'(c[3:0]), int'(r[3:0]));
            case (md)
               2'd1:    p = a & b;
               2'd2:    p = a ^ b;
`ifdef SET_CTRL_MODE3_EN
               2'd3:    p = ((int'(a) + int'(b) + int'(cc)) == 2);
`endif
               default: p = a;
            endcase
            if (p) n++;
         end
      end
      return n;
   endfunction

   // Scoreboard: every valid pulse must match the oldest outstanding job.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && sif.valid === 1'b1) begin
         if (exp_cnt_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_valid: valid=1 at cycle %0d with no job outstanding", cyc);
         end else begin
            sb_cnt = exp_cnt_q.pop_front();
            sb_cyc = exp_cyc_q.pop_front();
            n_vec += 3;
            if (int'(sif.candidate) != sb_cnt) begin
               n_err++;
               $display("FAIL sb_candidate: got %0d want %0d", sif.candidate, sb_cnt);
            end
            if (cyc != sb_cyc) begin
               n_err++;
               $display("FAIL sb_valid_cycle: got %0d want %0d", cyc, sb_cyc);
            end
            if (sif.busy !== 1'b1) begin
               n_err++;
               $display("FAIL sb_busy_in_valid: got %b want 1", sif.busy);
            end
         end
      end
   end

   // Call at a negedge; returns at the negedge after edge E.
   task automatic start_job(input logic [23:0] cen, input logic [11:0] rad, input logic [1:0] md);
      sif.en = 1'b1; sif.central = cen; sif.radius = rad; sif.mode = md;
      @(negedge clk);
      sif.en = 1'b0;
      exp_cnt_q.push_back(model_count(cen, rad, md));
      exp_cyc_q.push_back(cyc + 64 * k_of(md));
   endtask

   task automatic wait_valid(output bit to);
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (sif.valid === 1'b1) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      bit to;
      rst_n = 1'b0;
      sif.en = 1'b0; sif.central = '0; sif.radius = '0; sif.mode = '0;
      #1;
      n_vec += 3;
      if (sif.busy !== 1'b0 || sif.valid !== 1'b0) begin
         n_err++; $display("FAIL reset_busy_valid: got %b%b want 00", sif.busy, sif.valid);
      end
      if (sif.candidate !== 8'd0) begin
         n_err++; $display("FAIL reset_candidate: got %0d want 0", sif.candidate);
      end
      if ({cell_now, cell_cx, cell_cy, cell_r} !== 18'd0) begin
         n_err++; $display("FAIL reset_cell: got %h want 0", {cell_now, cell_cx, cell_cy, cell_r});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      to = 1'b0;
   endtask

   task automatic test_mode0;
      bit to;
      start_job(24'h440000, 12'h000, 2'd0);
      wait_valid(to);
      n_vec += 2;
      if (to) begin n_err++; $display("FAIL m0_r0_timeout: got none want valid"); end
      if (sif.candidate !== 8'd1) begin
         n_err++; $display("FAIL m0_r0_candidate: got %0d want 1", sif.candidate);
      end
      @(negedge clk);
      n_vec += 2;
      if (sif.busy !== 1'b0 || sif.valid !== 1'b0) begin
         n_err++; $display("FAIL m0_after_done: got busy=%b valid=%b want 0 0", sif.busy, sif.valid);
      end
      if (sif.candidate !== 8'd1) begin
         n_err++; $display("FAIL m0_hold: got %0d want 1", sif.candidate);
      end
      start_job(24'h440000, 12'h800, 2'd0);
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd64) begin
         n_err++; $display("FAIL m0_r8_candidate: got %0d want 64", sif.candidate);
      end
      @(negedge clk);
   endtask

   task automatic test_mode12;
      bit to;
      start_job(24'h112100, 12'h110, 2'd1);
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd2) begin
         n_err++; $display("FAIL m1_candidate: got %0d want 2", sif.candidate);
      end
      @(negedge clk);
      start_job(24'h112100, 12'h110, 2'd2);
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd3) begin
         n_err++; $display("FAIL m2_candidate: got %0d want 3", sif.candidate);
      end
      @(negedge clk);
   endtask

   task automatic test_mode3;
      bit to;
      logic [7:0] want;
`ifdef SET_CTRL_MODE3_EN
      want = 8'd2;
`else
      want = 8'd3;
`endif
      start_job(24'h112188, 12'h110, 2'd3);
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== want) begin
         n_err++; $display("FAIL m3_candidate: got %0d want %0d", sif.candidate, want);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_en;
      bit to;
      int extra = 0;
      start_job(24'h112100, 12'h110, 2'd1);
      repeat (9) @(negedge clk);
      sif.en = 1'b1; sif.central = 24'hFFFFFF; sif.mode = 2'd0;
      @(negedge clk);
      sif.en = 1'b0; sif.central = 24'h112100; sif.mode = 2'd1;
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd2) begin
         n_err++; $display("FAIL ignore_en_candidate: got %0d want 2", sif.candidate);
      end
      repeat (150) begin
         @(negedge clk);
         if (sif.valid === 1'b1) extra++;
      end
      n_vec++;
      if (extra != 0) begin
         n_err++; $display("FAIL ignore_en_queued: got %0d extra valid want 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      bit to;
      start_job(24'h440000, 12'h000, 2'd0);
      wait_valid(to);
      @(negedge clk);
      start_job(24'h112100, 12'h110, 2'd2);
      n_vec++;
      if (sif.busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_accept: got busy=%b want 1", sif.busy);
      end
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd3) begin
         n_err++; $display("FAIL b2b_candidate: got %0d want 3", sif.candidate);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_job;
      bit to;
      int seen = 0;
      start_job(24'h112100, 12'h110, 2'd1);
      repeat (50) @(negedge clk);
      #1 rst_n = 1'b0;
      exp_cnt_q.delete();
      exp_cyc_q.delete();
      #1;
      n_vec += 2;
      if (sif.busy !== 1'b0 || sif.valid !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_busy_valid: got %b%b want 00", sif.busy, sif.valid);
      end
      if (sif.candidate !== 8'd0) begin
         n_err++; $display("FAIL mid_reset_candidate: got %0d want 0", sif.candidate);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (sif.valid === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++; $display("FAIL mid_reset_ghost_valid: got %0d want 0", seen);
      end
      start_job(24'h112100, 12'h110, 2'd1);
      wait_valid(to);
      n_vec++;
      if (to || sif.candidate !== 8'd2) begin
         n_err++; $display("FAIL restart_candidate: got %0d want 2", sif.candidate);
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      bit to;
      logic [23:0] c;
      logic [11:0] r;
      for (int j = 0; j < 8; j++) begin
         for (int f = 0; f < 6; f++) c[f*4 +: 4] = 4'($urandom_range(0, 9));
         for (int f = 0; f < 3; f++) r[f*4 +: 4] = 4'($urandom_range(0, 8));
         start_job(c, r, 2'($urandom_range(0, 3)));
         wait_valid(to);
         n_vec++;
         if (to) begin n_err++; $display("FAIL random_timeout: job %0d got none want valid", j); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode12();
      test_mode3();
      test_ignore_en();
      test_back_to_back();
      test_reset_mid_job();
      test_random();
      repeat (2) @(negedge clk);
      n_vec++;
      if (exp_cnt_q.size() != 0) begin
         n_err++; $display("FAIL sb_drain: got %0d outstanding want 0", exp_cnt_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/set_scan_ctrl.md
# set_scan_ctrl

Sequencing controller for the shared circle-membership cell, the combinational map cell that answers "is grid point `now` inside circle (cx, cy, r)". On a start pulse it latches up to three circles and a counting mode. It then walks all 64 points of the 8×8 grid, time-multiplexing the single cell across the circles, and returns the number of points that satisfy the mode. It sits between the top-level set interface and the one map-cell instance.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  start pulse; sampled only when `busy`=0
- `central`  in  24  `[23:20]`=xA, `[19:16]`=yA, `[15:12]`=xB, `[11:8]`=yB, `[7:4]`=xC, `[3:0]`=yC
- `radius`  in  12  `[11:8]`=rA, `[7:4]`=rB, `[3:0]`=rC
- `mode`  in  2  counting mode, latched with `en`
- `busy`  out  1  job in progress
- `valid`  out  1  one-cycle pulse, `candidate` valid
- `candidate`  out  8  point count, 0..64
- `cell_now`  out  6  point index to cell; `[2:0]`=x−1, `[5:3]`=y−1
- `cell_cx`, `cell_cy`, `cell_r`  out  4 each  selected circle to cell
- `cell_in`  in  1  cell result, combinational on `cell_*` in the same cycle

## Operation
- States:
  - IDLE: `busy`=0. `en`=1 latches `central`, `radius` and `mode`, clears the point index, circle select and counter, then goes to EVAL.
  - EVAL: one circle evaluated per cycle.
  - DONE: one cycle, then returns to IDLE.
- Circles per point: k=1 for mode 0, k=2 for modes 1 and 2, k=3 for mode 3. Order is A, B, C.
- Points are scanned in index order 0..63. The circle select cycles 0..k−1 and the point index advances after the last circle of each point.
- Hit bits for A and B are registered per point. On the last circle cycle, the point predicate is computed from the registered bits plus the live `cell_in`. If the predicate is true, the 7-bit counter increments.
- Point predicates by mode:
  - mode 0: point is in A.
  - mode 1: point is in A and in B.
  - mode 2: point is in A XOR B.
  - mode 3: point is in exactly two of A, B, C.
- EVAL goes to DONE after point 63 completes. In DONE, `candidate` is loaded from the counter, zero-extended, and `valid`=1.
- `cell_*` outputs are driven from state registers, never from inputs directly. They read 0 in IDLE and DONE.
- Contract range: centers 0..9, radii 0..8. Values outside this range give an unspecified count but always finish in 64k cycles and never hang.
- `en` while `busy`=1 is ignored and does not queue.
- `rst_n` low at any time, including mid-job, forces IDLE immediately. No `valid` pulse follows the reset and any partial count is discarded.

## Timing
- Reset values:
  - `busy`=0, `valid`=0, `candidate`=0.
  - `cell_now`=0, `cell_cx`=0, `cell_cy`=0, `cell_r`=0.
  - All internal state is 0 and the FSM is in IDLE.
- Call the rising edge that samples `en`=1 edge E. `busy`=1 after E.
- The EVAL cycles are the 64k cycles following E.
- `valid`=1 after edge E+64k, for exactly one cycle.
- `busy`=0 after edge E+64k+1. `busy` stays high during the `valid` cycle.
- `candidate` holds its value until the next job's DONE or a reset.
- A new `en` is accepted at the first edge where `busy`=0, so back-to-back jobs have no extra gap.

## Configuration
- `SET_CTRL_MODE3_EN` defined:
  - mode 3 and circle C are implemented as described above.
- `SET_CTRL_MODE3_EN` undefined:
  - mode 3 is treated exactly as mode 0 (k=1, count points in A).
  - Circle C is never presented to the cell.
  - The C hit logic is not built.

## Test plan
- Mode 0, A=(4,4), rA=0 -> `valid` after E+64, `candidate`=1, `busy` low after E+65.
- Mode 0, A=(4,4), rA=8 -> `candidate`=64, `valid` after E+64.
- Mode 1, A=(1,1) r1, B=(2,1) r1 -> `candidate`=2 after E+128. Then mode 2 with the same circles -> `candidate`=3 after E+128.
- Mode 3, A=(1,1) r1, B=(2,1) r1, C=(8,8) r0:
  - With `SET_CTRL_MODE3_EN` defined -> `candidate`=2 after E+192.
  - Without it -> `candidate`=3 after E+64.
- Start mode 1, pulse `en` again at E+10 -> ignored, single `valid` at E+128. Back-to-back `en` right after `busy` falls -> accepted.
- Assert `rst_n`=0 at E+50 -> `busy`, `valid` and `candidate` read 0 immediately and no `valid` pulse follows. A job restarted after reset gives the correct count.
